// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one shared full adder (two half adders
// plus an OR) walks the operands LSB first, one bit per hz100 edge.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = 5
) (
  input  logic             hz100,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] opa, opb, part;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic s0, c0, fs, c1, fc;
  logic last;

  half_adder u_ha0 (.x(opa[0]), .y(opb[0]), .s(s0), .c(c0));
  half_adder u_ha1 (.x(s0),     .y(carry),  .s(fs), .c(c1));
  assign fc   = c0 | c1;
  assign last = (cnt == CW'(WIDTH-1));

  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      opa   <= '0;
      opb   <= '0;
      part  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // subtract as a + ~b + 1: the +1 enters as the initial carry
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          part  <= {fs, part[WIDTH-1:1]};
          carry <= fc;
          if (last) begin
            // carry still holds the carry into the MSB at this point
            sum   <= {fs, part[WIDTH-1:1]};
            cout  <= fc;
            ovf   <= carry ^ fc;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
